// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: memory access size encodings and the data-memory controller FSM states.
package rv32i_pkg;

  localparam logic [1:0] SIZE_W    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_B    = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } mem_ctrl_state_t;

endpackage

// File: rtl/data_mem_ctrl_align_check.sv
// Combinational alignment check: flags word accesses off a 4-byte boundary and
// half-word accesses off a 2-byte boundary. Byte and none never misalign.
module align_check (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  output logic       misaligned_o
);
  import rv32i_pkg::*;

  // Decode the access size against the low address bits.
  always_comb begin
    misaligned_o = 1'b0;
    unique case (size_i)
      SIZE_W:  misaligned_o = (addr_lo_i != 2'b00);
      SIZE_H:  misaligned_o = addr_lo_i[0];
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller between mem_stage and the external data bus.
// Runs a registered req/ack handshake, returns read data, stalls the pipeline
// while an access is outstanding, and flags misaligned accesses and timeouts.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        require_mem_access,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_to_mem,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack_n,
  input  logic [31:0] bus_rdata,
  output logic [31:0] data_from_mem,
  output logic        data_mem_access_ready_n,
  output logic        stall,
  output logic        misaligned,
  output logic        timeout_err
);
  import rv32i_pkg::*;

  mem_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             bus_req_q, bus_req_d;
  logic             bus_write_q, bus_write_d;
  logic [1:0]       bus_size_q, bus_size_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             misaligned_q, misaligned_d;
  logic             timeout_q, timeout_d;

  logic addr_misaligned;
  logic req_active;
  logic valid_req;
  logic mis_req;
  logic timeout_hit;

  align_check u_align_check (
    .size_i       (size),
    .addr_lo_i    (data_mem_addr[1:0]),
    .misaligned_o (addr_misaligned)
  );

  assign req_active = require_mem_access && (size != SIZE_NONE);
  assign valid_req  = req_active && !addr_misaligned;
  assign mis_req    = req_active && addr_misaligned;

  // cnt_inc is the number of WAIT cycles including the current one.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and next-register values; ack takes priority over timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_write_d  = bus_write_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    rdata_d      = rdata_q;
    misaligned_d = 1'b0;
    timeout_d    = timeout_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (valid_req) begin
          bus_req_d   = 1'b1;
          bus_write_d = write;
          bus_size_d  = size;
          bus_addr_d  = data_mem_addr;
          bus_wdata_d = data_to_mem;
          state_d     = StWait;
        end else if (mis_req) begin
          misaligned_d = 1'b1;
          rdata_d      = '0;
        end
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (!bus_ack_n) begin
          if (!bus_write_q) begin
            rdata_d = bus_rdata;
          end
          bus_req_d = 1'b0;
          state_d   = StDone;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = StDone;
        end
      end
      StDone: begin
        // The request still belongs to the instruction that just completed.
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops bus_req immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_size_q   <= SIZE_NONE;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_write_q  <= bus_write_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      rdata_q      <= rdata_d;
      misaligned_q <= misaligned_d;
      timeout_q    <= timeout_d;
    end
  end

  // Pipeline handshake: hold the pipeline from request detection until DONE.
  always_comb begin
    stall                   = ((state_q == StIdle) && valid_req) || (state_q == StWait);
    data_mem_access_ready_n = stall;
  end

  assign bus_req       = bus_req_q;
  assign bus_write     = bus_write_q;
  assign bus_size      = bus_size_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign data_from_mem = rdata_q;
  assign misaligned    = misaligned_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: dut0 uses the default timeout, dut1 a 4-cycle timeout.
// Expected read data is queued when a request is driven and compared on completion.
module tb_data_mem_ctrl;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, write;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        ack0_n, ack1_n, force_noack;

  logic        bus_req0, bus_write0, ready_n0, stall0, mis0, to0;
  logic [1:0]  bus_size0;
  logic [31:0] bus_addr0, bus_wdata0, dfm0;
  logic        bus_req1, bus_write1, ready_n1, stall1, mis1, to1;
  logic [1:0]  bus_size1;
  logic [31:0] bus_addr1, bus_wdata1, dfm1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] dfm_model;

  assign ack1_n = ack0_n | force_noack;

  always #5 clk = ~clk;

  data_mem_ctrl u_dut0 (
    .clk(clk), .rst(rst), .require_mem_access(req), .write(write), .size(size),
    .data_mem_addr(addr), .data_to_mem(wdata), .bus_req(bus_req0), .bus_write(bus_write0),
    .bus_size(bus_size0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_ack_n(ack0_n),
    .bus_rdata(rdata), .data_from_mem(dfm0), .data_mem_access_ready_n(ready_n0),
    .stall(stall0), .misaligned(mis0), .timeout_err(to0)
  );

  data_mem_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .require_mem_access(req), .write(write), .size(size),
    .data_mem_addr(addr), .data_to_mem(wdata), .bus_req(bus_req1), .bus_write(bus_write1),
    .bus_size(bus_size1), .bus_addr(bus_addr1), .bus_wdata(bus_wdata1), .bus_ack_n(ack1_n),
    .bus_rdata(rdata), .data_from_mem(dfm1), .data_mem_access_ready_n(ready_n1),
    .stall(stall1), .misaligned(mis1), .timeout_err(to1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One access on dut0 with ack in the k-th WAIT cycle; returns in DONE if hold is set.
  task automatic do_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int k,
                           input bit hold, input string tag);
    int          c;
    int          nw;
    bit          done;
    logic [31:0] exp;
    if (!w) dfm_model = rd;
    exp_q.push_back(dfm_model);
    write = w; size = sz; addr = a; wdata = wd; rdata = rd; req = 1'b1; ack0_n = 1'b1;
    #1;
    c = 0; nw = 0; done = 0;
    while (!done && c < 300) begin
      check({tag, " stall"}, 32'(stall0), 32'd1);
      if (bus_req0) begin
        nw++;
        ack0_n = (nw == k) ? 1'b0 : 1'b1;
        check({tag, " bus_addr"}, bus_addr0, a);
        check({tag, " bus_wdata"}, bus_wdata0, wd);
        check({tag, " bus_size"}, 32'(bus_size0), 32'(sz));
        check({tag, " bus_write"}, 32'(bus_write0), 32'(w));
      end else begin
        ack0_n = 1'b1;
      end
      cyc();
      c++;
      if (!ready_n0) done = 1;
    end
    ack0_n = 1'b1;
    check({tag, " latency"}, 32'(c + 1), 32'(k + 2));
    exp = exp_q.pop_front();
    check({tag, " data_from_mem"}, dfm0, exp);
    check({tag, " done stall"}, 32'(stall0), 32'd0);
    check({tag, " done bus_req"}, 32'(bus_req0), 32'd0);
    if (!hold) begin
      req = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            nw1;
    int            c;
    logic [1:0]    mis_sz[3]   = '{SIZE_W, SIZE_W, SIZE_H};
    logic [31:0]   mis_addr[3] = '{32'h0000_1235, 32'h0000_1236, 32'h0000_1231};

    rst = 1'b1; req = 1'b0; write = 1'b0; size = SIZE_NONE; addr = '0; wdata = '0;
    rdata = '0; ack0_n = 1'b1; force_noack = 1'b0; dfm_model = '0;
    #1;
    check("rst bus_req", 32'(bus_req0), 32'd0);
    check("rst bus_write", 32'(bus_write0), 32'd0);
    check("rst bus_size", 32'(bus_size0), 32'd3);
    check("rst bus_addr", bus_addr0, 32'd0);
    check("rst bus_wdata", bus_wdata0, 32'd0);
    check("rst data_from_mem", dfm0, 32'd0);
    check("rst ready_n", 32'(ready_n0), 32'd0);
    check("rst stall", 32'(stall0), 32'd0);
    check("rst misaligned", 32'(mis0), 32'd0);
    check("rst timeout_err", 32'(to0), 32'd0);
    check("rst dut1 bus", {bus_wdata1[15:0], bus_addr1[11:0], bus_size1, bus_write1, bus_req1},
          32'h0000_000c);
    check("rst dut1 flags", {27'd0, dfm1 != 0, ready_n1, stall1, mis1, to1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Load with immediate ack, store with delayed ack, byte load.
    do_access(1'b0, SIZE_W, 32'h0000_1234, 32'h0, 32'ha0b1_c2d3, 1, 1'b0, "lw");
    do_access(1'b1, SIZE_H, 32'h0000_2002, 32'h4321_4321, 32'hdead_beef, 5, 1'b0, "sh");
    do_access(1'b0, SIZE_B, 32'h0000_3003, 32'h0, 32'h0000_00a5, 3, 1'b0, "lb");

    // Misaligned requests: no bus cycle, one-cycle flag, data cleared.
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; write = 1'b0; size = mis_sz[i]; addr = mis_addr[i];
      #1;
      check("mis stall", 32'(stall0), 32'd0);
      check("mis ready_n", 32'(ready_n0), 32'd0);
      dfm_model = '0;
      exp_q.push_back(dfm_model);
      cyc();
      req = 1'b0;
      check("mis pulse", 32'(mis0), 32'd1);
      check("mis bus_req", 32'(bus_req0), 32'd0);
      check("mis data_from_mem", dfm0, exp_q.pop_front());
      cyc();
      check("mis pulse end", 32'(mis0), 32'd0);
      check("mis bus_req later", 32'(bus_req0), 32'd0);
    end

    // Size none is not an access.
    req = 1'b1; size = SIZE_NONE; addr = 32'h0000_0040;
    #1;
    check("none stall", 32'(stall0), 32'd0);
    cyc();
    req = 1'b0;
    check("none bus_req", 32'(bus_req0), 32'd0);
    check("none misaligned", 32'(mis0), 32'd0);

    // Request held through DONE: no reissue, then a fresh access from IDLE.
    do_access(1'b0, SIZE_W, 32'h0000_4000, 32'h0, 32'h1111_2222, 2, 1'b1, "hold1");
    cyc();
    check("hold no reissue", 32'(bus_req0), 32'd0);
    do_access(1'b0, SIZE_W, 32'h0000_4004, 32'h0, 32'h3333_4444, 1, 1'b0, "hold2");

    // Timeout on dut1 (limit 4); dut0 keeps waiting and is then acked.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    dfm_model = '0;
    cyc();
    do_access(1'b0, SIZE_W, 32'h0000_0100, 32'h0, 32'h5555_aaaa, 2, 1'b0, "pre_to");
    check("pre_to dut1 data", dfm1, 32'h5555_aaaa);
    force_noack = 1'b1;
    req = 1'b1; write = 1'b0; size = SIZE_W; addr = 32'h0000_0104; rdata = 32'h7777_8888;
    #1;
    nw1 = 0;
    c = 0;
    while (c < 20) begin
      if (bus_req1) nw1++;
      cyc();
      c++;
      if (nw1 > 0 && !bus_req1) break;
    end
    check("to wait cycles", 32'(nw1), 32'd4);
    check("to timeout_err", 32'(to1), 32'd1);
    check("to data_from_mem", dfm1, 32'd0);
    check("to ready_n", 32'(ready_n1), 32'd0);
    check("to dut0 still waiting", 32'(bus_req0), 32'd1);
    check("to dut0 no timeout", 32'(to0), 32'd0);
    req = 1'b0;
    ack0_n = 1'b0;
    dfm_model = 32'h7777_8888;
    cyc();
    ack0_n = 1'b1;
    check("to dut0 late ack data", dfm0, dfm_model);
    cyc();
    force_noack = 1'b0;
    do_access(1'b0, SIZE_W, 32'h0000_0108, 32'h0, 32'h9999_0000, 1, 1'b0, "after_to");
    check("to sticky", 32'(to1), 32'd1);
    check("after_to dut1 data", dfm1, 32'h9999_0000);
    check("after_to dut0 flag", 32'(to0), 32'd0);

    // Reset mid-WAIT, then a byte load.
    req = 1'b1; write = 1'b0; size = SIZE_W; addr = 32'h0000_0200; wdata = 32'hffff_0000;
    rdata = 32'h0; ack0_n = 1'b1;
    cyc();
    check("rst_mid in wait", 32'(bus_req0), 32'd1);
    cyc();
    #2 rst = 1'b1;
    #1;
    check("rst_mid bus_req", 32'(bus_req0), 32'd0);
    check("rst_mid bus_size", 32'(bus_size0), 32'd3);
    check("rst_mid bus_addr", bus_addr0, 32'd0);
    check("rst_mid bus_wdata", bus_wdata0, 32'd0);
    check("rst_mid data_from_mem", dfm0, 32'd0);
    check("rst_mid dut1 timeout_err", 32'(to1), 32'd0);
    req = 1'b0;
    dfm_model = '0;
    @(negedge clk);
    rst = 1'b0;
    cyc();
    do_access(1'b0, SIZE_B, 32'h0000_0002, 32'h0, 32'h0000_00c3, 2, 1'b0, "lb_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
